icache_sa: RTL
==============

Name: icache_sa

Overview:
- Parametrised N-way set-associative instruction cache between the IF stage and the memory controller. Successor to the direct-mapped single-port iCache.
- Hits return the instruction combinationally in the same cycle.
- On a miss the block owns the refill: it issues a block request to memory, waits for the response, installs the block with round-robin replacement, then serves the hit.
- Adds a fence.i-style whole-cache invalidate.

Parameters:
- ADDR_W, 32, byte address width.
- INSTR_W, 32, instruction width in bits.
- IDX_W, 4, set-index bits (sets = 2**IDX_W).
- OFF_W, 2, instruction-offset bits within a block (instrs per block = 2**OFF_W).
- WAYS, 2, associativity, power of two, 1..8.
- Derived: TAG_W = ADDR_W-IDX_W-OFF_W-2; BLK_W = INSTR_W<<OFF_W.

Ports:
- clk  in  1  system clock.
- rst_in  in  1  asynchronous active-high reset.
- flush  in  1  invalidate all lines (fence.i / branch-recovery policy).
- if_req  in  1  IF presents a fetch address this cycle.
- if_ain  in  ADDR_W  fetch address; bits [1:0] ignored.
- if_instr_out_en  out  1  instruction valid this cycle.
- if_instr_out  out  INSTR_W  fetched instruction; 0 when not valid.
- mem_req_en  out  1  block request valid.
- mem_req_addr  out  ADDR_W  block-aligned request address (offset and byte bits zero).
- mem_req_rdy  in  1  memory accepts the request this cycle.
- mem_resp_en  in  1  refill block valid (one-cycle pulse).
- mem_resp_data  in  BLK_W  refill block; instruction k at bits [k*INSTR_W +: INSTR_W].

Behaviour:
- Reset (async, any time, including mid-refill):
  - All valid bits = 0; replacement pointers = 0; FSM = IDLE; discard flag = 0.
  - Outputs: if_instr_out_en=0, if_instr_out=0, mem_req_en=0, mem_req_addr=0.
  - Tag/data arrays need no reset.
- Lookup: if_ain is split into tag/idx/off. hit = if_req && any way w has valid[idx][w] && tag[idx][w]==tag.
  - At most one way may match. A multi-match is a bug; the bench asserts it never happens.
- Hit path: if_instr_out_en=hit and if_instr_out=data[idx][way][off] in the same cycle (zero latency), in any FSM state. Hits under a pending miss are allowed.
- FSM states IDLE, REQ, WAIT:
  - IDLE: on if_req && !hit && !flush, latch the block address from if_ain and go to REQ.
  - REQ: mem_req_en=1, mem_req_addr = latched address. mem_req_addr is held stable until mem_req_rdy=1, then go to WAIT.
  - WAIT: on mem_resp_en, write the block to the victim way, set valid and tag, and go to IDLE. The requesting address hits on the next cycle.
  - Miss latency = 1 (IDLE→REQ) + handshake + response + 1 cycle until hit.
- Victim choice: the lowest-numbered invalid way in the set if one exists, else rr_ptr[idx]. rr_ptr[idx] increments modulo WAYS only when a valid line is evicted.
- IF changes address during a miss: the refill completes for the latched address regardless. The new address is treated as a fresh miss once the FSM is back in IDLE.
- Flush: clears all valid bits at the clock edge; rr_ptrs are unchanged.
  - Flush in REQ: the request is still completed (no retraction of mem_req_en) and the discard flag is set.
  - Flush in WAIT: the discard flag is set.
  - Response while discard=1: the data is dropped, discard is cleared, and the FSM goes to IDLE.
  - Flush coincident with mem_resp_en: the response is dropped and flush wins.
  - Hits are suppressed during the flush cycle: if_instr_out_en=0.
- Fill coincident with a lookup of the same set: the lookup uses the pre-write contents. Write-first forwarding is not required.
- if_req=0: no miss is triggered and outputs are 0.

Decomposition:
- Shared package/header (extends the existing param include):
  - ICACHE_IDX_W, ICACHE_OFF_W, ICACHE_WAYS defaults.
  - Derived TAG_W/BLK_W macros.
  - FSM state encodings ICS_IDLE=2'd0, ICS_REQ=2'd1, ICS_WAIT=2'd2.
- One natural sub-module: icache_way, one tag/valid/data way with a lookup-match output, a read-data output and a write port. It is instantiated WAYS times via generate. The top level holds the FSM, the victim selection and the hit mux.

Test Plan:
- Cold miss, default params, memory ready after 2 cycles, response 3 cycles later, if_ain=0x0000_0104:
  - mem_req_addr=0x0000_0100 is held through the handshake.
  - After the fill, if_instr_out = word 1 of the block, en=1.
  - Every other address in the block 0x100..0x10C hits at zero latency.
- Associativity conflict with WAYS=2: fill 0x0000_0100, 0x0000_0500 and 0x0000_0900 (same set, index 0).
  - The first two fill ways 0 and 1.
  - The third evicts way 0; 0x100 then misses and 0x500 still hits.
- Hit under miss: while waiting on 0x900, fetch 0x500 -> en=1 with correct data the same cycle, and the FSM stays in WAIT.
- Flush during WAIT, then the response arrives -> data dropped, FSM returns to IDLE, all prior addresses miss, and the next miss issues a new request.
- Async reset asserted mid-REQ -> mem_req_en drops immediately (no clock edge) and all lines are invalid after release.
- Parameter sweep with WAYS=1, WAYS=4 and OFF_W=3 -> random fetch stream against a reference memory, with zero mismatches over 10k fetches.

Source files
------------

// File: rtl/icache_sa_pkg.sv
// icache_sa_pkg: default geometry, FSM state encoding and derived-width helpers for icache_sa
package icache_sa_pkg;
  localparam int ICACHE_IDX_W = 4;
  localparam int ICACHE_OFF_W = 2;
  localparam int ICACHE_WAYS = 2;
  typedef enum logic [1:0] {
    ICS_IDLE = 2'd0,
    ICS_REQ  = 2'd1,
    ICS_WAIT = 2'd2
  } ics_e;
  function automatic int tag_w(int addr_w, int idx_w, int off_w);
    return addr_w - idx_w - off_w - 2;
  endfunction
  function automatic int blk_w(int instr_w, int off_w);
    return instr_w << off_w;
  endfunction
endpackage

// File: rtl/icache_sa_if.sv
// icache_sa_if: fetch side (flush, if_req, if_ain, if_instr_out_en, if_instr_out) and refill side (mem_req_en/addr/rdy, mem_resp_en/data) of icache_sa
interface icache_sa_if import icache_sa_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter int INSTR_W = 32,
  parameter int OFF_W = ICACHE_OFF_W
) ();
  localparam int BLK_W = blk_w(INSTR_W, OFF_W);
  logic flush;
  logic if_req;
  logic [ADDR_W-1:0] if_ain;
  logic if_instr_out_en;
  logic [INSTR_W-1:0] if_instr_out;
  logic mem_req_en;
  logic [ADDR_W-1:0] mem_req_addr;
  logic mem_req_rdy;
  logic mem_resp_en;
  logic [BLK_W-1:0] mem_resp_data;
  modport master (
    output flush, if_req, if_ain, mem_req_rdy, mem_resp_en, mem_resp_data,
    input if_instr_out_en, if_instr_out, mem_req_en, mem_req_addr
  );
  modport slave (
    input flush, if_req, if_ain, mem_req_rdy, mem_resp_en, mem_resp_data,
    output if_instr_out_en, if_instr_out, mem_req_en, mem_req_addr
  );
endinterface

// File: rtl/icache_sa_way.sv
// icache_way: one way (valid/tag/data per set); ports: lookup ridx/rtag/roff -> match/rdata, fill we/widx/wtag/wdata, wvalid = valid[widx], clr wipes valids
module icache_way #(
  parameter int IDX_W = 4,
  parameter int TAG_W = 24,
  parameter int OFF_W = 2,
  parameter int INSTR_W = 32,
  parameter int BLK_W = 128
) (
  input logic clk,
  input logic rst_in,
  input logic clr,
  input logic [IDX_W-1:0] ridx,
  input logic [TAG_W-1:0] rtag,
  input logic [OFF_W-1:0] roff,
  output logic match,
  output logic [INSTR_W-1:0] rdata,
  input logic we,
  input logic [IDX_W-1:0] widx,
  input logic [TAG_W-1:0] wtag,
  input logic [BLK_W-1:0] wdata,
  output logic wvalid
);
  localparam int SETS = 1 << IDX_W;
  logic [SETS-1:0] valid;
  logic [TAG_W-1:0] tags [SETS];
  logic [BLK_W-1:0] data [SETS];
  always_ff @(posedge clk or posedge rst_in)
    if (rst_in) valid <= '0;
    else if (clr) valid <= '0;
    else if (we) valid[widx] <= 1'b1;
  always_ff @(posedge clk)
    if (we) begin
      tags[widx] <= wtag;
      data[widx] <= wdata;
    end
  assign match = valid[ridx] && tags[ridx] == rtag;
  assign rdata = data[ridx][roff*INSTR_W +: INSTR_W];
  assign wvalid = valid[widx];
endmodule

// File: rtl/icache_sa.sv
// icache_sa: WAYS-way set-associative icache; clk, rst_in (async), bus.slave carries fetch lookup (zero-latency hit) and block refill handshake
module icache_sa import icache_sa_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter int INSTR_W = 32,
  parameter int IDX_W = ICACHE_IDX_W,
  parameter int OFF_W = ICACHE_OFF_W,
  parameter int WAYS = ICACHE_WAYS
) (
  input logic clk,
  input logic rst_in,
  icache_sa_if.slave bus
);
  localparam int TAG_W = tag_w(ADDR_W, IDX_W, OFF_W);
  localparam int BLK_W = blk_w(INSTR_W, OFF_W);
  localparam int SETS = 1 << IDX_W;
  localparam int BA_W = ADDR_W - OFF_W - 2;
  localparam int VW = WAYS > 1 ? $clog2(WAYS) : 1;
  ics_e state, state_n;
  logic [BA_W-1:0] blk_q;
  logic discard;
  logic [VW-1:0] rr [SETS];
  logic [VW-1:0] victim;
  logic [WAYS-1:0] match, wv, we;
  logic [INSTR_W-1:0] rd [WAYS];
  logic [INSTR_W-1:0] instr;
  logic [IDX_W-1:0] fidx;
  logic [TAG_W-1:0] ftag;
  logic hit_any, en, miss, fill;
  assign fidx = blk_q[IDX_W-1:0];
  assign ftag = blk_q[BA_W-1:IDX_W];
  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign we[w] = fill && victim == VW'(w);
    icache_way #(.IDX_W(IDX_W), .TAG_W(TAG_W), .OFF_W(OFF_W), .INSTR_W(INSTR_W), .BLK_W(BLK_W)) u_way (
      .clk(clk),
      .rst_in(rst_in),
      .clr(bus.flush),
      .ridx(bus.if_ain[OFF_W+2 +: IDX_W]),
      .rtag(bus.if_ain[ADDR_W-1 -: TAG_W]),
      .roff(bus.if_ain[2 +: OFF_W]),
      .match(match[w]),
      .rdata(rd[w]),
      .we(we[w]),
      .widx(fidx),
      .wtag(ftag),
      .wdata(bus.mem_resp_data),
      .wvalid(wv[w])
    );
  end
  always_comb begin
    instr = '0;
    for (int i = 0; i < WAYS; i++) instr = instr | (match[i] ? rd[i] : '0);
  end
  // lowest invalid way wins; round-robin pointer only when the set is full
  always_comb begin
    victim = rr[fidx];
    for (int i = WAYS - 1; i >= 0; i--) victim = wv[i] ? victim : VW'(i);
  end
  assign hit_any = |match;
  assign en = bus.if_req && hit_any && !bus.flush;
  assign miss = state == ICS_IDLE && bus.if_req && !hit_any && !bus.flush;
  assign fill = state == ICS_WAIT && bus.mem_resp_en && !discard && !bus.flush;
  always_comb begin
    state_n = state;
    if (miss) state_n = ICS_REQ;
    if (state == ICS_REQ && bus.mem_req_rdy) state_n = ICS_WAIT;
    if (state == ICS_WAIT && bus.mem_resp_en) state_n = ICS_IDLE;
  end
  always_ff @(posedge clk or posedge rst_in)
    if (rst_in) begin
      state <= ICS_IDLE;
      blk_q <= '0;
      discard <= 1'b0;
      for (int s = 0; s < SETS; s++) rr[s] <= '0;
    end else begin
      state <= state_n;
      if (miss) blk_q <= bus.if_ain[ADDR_W-1:OFF_W+2];
      if (state == ICS_WAIT && bus.mem_resp_en) discard <= 1'b0;
      else if (bus.flush && state != ICS_IDLE) discard <= 1'b1;
      if (fill && &wv) rr[fidx] <= VW'((int'(rr[fidx]) + 1) % WAYS);
    end
  assign bus.if_instr_out_en = en;
  assign bus.if_instr_out = en ? instr : '0;
  assign bus.mem_req_en = state == ICS_REQ;
  assign bus.mem_req_addr = state == ICS_REQ ? {blk_q, (OFF_W+2)'(0)} : '0;
endmodule
